// File: rtl/rock_motion_gen_pkg.sv
// Shared types and constants for the cradle motion generator.
// Positions are signed; intermediate sums use one extra bit so they never wrap.
package rock_pkg;

    localparam int AMP_SHIFT = 4;
    localparam int POS_W     = 8;
    localparam int PWM_W     = 7;
    localparam int AMP_W     = 3 + AMP_SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOME
    } state_t;

    typedef logic signed [POS_W:0] wide_t;

    // |pos| never exceeds 112, so the magnitude always fits the PWM counter width.
    function automatic logic [PWM_W-1:0] pos_mag(input logic signed [POS_W-1:0] p);
        return PWM_W'(p[POS_W-1] ? -p : p);
    endfunction

endpackage

// File: rtl/rock_motion_gen_if.sv
// Settings from the controller and the cradle drive outputs, bundled as one port.
interface rock_motion_gen_if;
    import rock_pkg::*;

    logic [2:0]              A;
    logic [2:0]              F;
    logic                    error;
    logic signed [POS_W-1:0] pos;
    logic                    dir;
    logic                    pwm;
    logic                    center;
    logic                    busy;

    modport master (
        output A, F, error,
        input  pos, dir, pwm, center, busy
    );

    modport slave (
        input  A, F, error,
        output pos, dir, pwm, center, busy
    );

endinterface

// File: rtl/rock_motion_gen_tick.sv
// Motion tick divider: one-clk tick every TICK_DIV clks, the first one
// TICK_DIV clks after reset release.
module rock_tick #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rock_motion_gen.sv
// Cradle motion generator: triangular swing between +/-amp, settings applied only
// at centre crossings, homing to centre on fault, PWM duty proportional to |pos|.
module rock_motion_gen
    import rock_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int HOME_STEP = 2
) (
    input logic              clk,
    input logic              reset,
    rock_motion_gen_if.slave bus
);

    localparam logic signed [POS_W-1:0] ZERO   = '0;
    localparam logic signed [POS_W-1:0] HOME_S = POS_W'(HOME_STEP);

    state_t                  state, state_nxt;
    logic signed [POS_W-1:0] pos_q, pos_nxt, home_dn, home_up;
    logic                    dir_q, dir_nxt;
    logic [AMP_W-1:0]        amp_l, amp_nxt;
    logic [2:0]              step_l, step_nxt;
    logic                    center_nxt, cross_q, center_q;
    logic [PWM_W-1:0]        pwm_cnt;
    logic                    pwm_q;
    logic                    tick;
    logic                    settings_ok;
    wide_t                   pos_w, step_w, amp_w, neg_amp, run_sum;

    rock_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(reset),
        .tick (tick)
    );

    assign settings_ok = (|bus.A) && (|bus.F);
    assign pos_w       = {pos_q[POS_W-1], pos_q};
    assign step_w      = {{(POS_W - 2){1'b0}}, step_l};
    assign amp_w       = {{(POS_W + 1 - AMP_W){1'b0}}, amp_l};
    assign neg_amp     = -amp_w;
    assign run_sum     = dir_q ? pos_w + step_w : pos_w - step_w;
    assign home_dn     = pos_q - HOME_S;
    assign home_up     = pos_q + HOME_S;

    // NOTE: registers take <= so every one of them samples the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            amp_l    <= '0;
            step_l   <= '0;
            cross_q  <= 1'b0;
            center_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos_q    <= pos_nxt;
            dir_q    <= dir_nxt;
            amp_l    <= amp_nxt;
            step_l   <= step_nxt;
            cross_q  <= center_nxt;
            center_q <= cross_q;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt  = state;
        pos_nxt    = pos_q;
        dir_nxt    = dir_q;
        amp_nxt    = amp_l;
        step_nxt   = step_l;
        center_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (tick && settings_ok && !bus.error) begin
                    amp_nxt   = {bus.A, {AMP_SHIFT{1'b0}}};
                    step_nxt  = bus.F;
                    pos_nxt   = {{(POS_W - 3){1'b0}}, bus.F};
                    dir_nxt   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A fault overrides any motion on this clk; pos waits for the next tick.
                if (bus.error) begin
                    state_nxt = HOME;
                end else if (tick) begin
                    if (dir_q) begin
                        if (run_sum >= amp_w) begin
                            pos_nxt = amp_w[POS_W-1:0];
                            dir_nxt = 1'b0;
                        end else begin
                            pos_nxt = run_sum[POS_W-1:0];
                        end
                    end else begin
                        if (run_sum <= neg_amp) begin
                            pos_nxt = neg_amp[POS_W-1:0];
                            dir_nxt = 1'b1;
                        end else begin
                            pos_nxt = run_sum[POS_W-1:0];
                        end
                    end
                    center_nxt = (pos_q > ZERO && pos_nxt <= ZERO) ||
                                 (pos_q < ZERO && pos_nxt >= ZERO);
                    if (center_nxt) begin
                        if (settings_ok) begin
                            amp_nxt  = {bus.A, {AMP_SHIFT{1'b0}}};
                            step_nxt = bus.F;
                        end else begin
                            state_nxt = HOME;
                        end
                    end
                end
            end
            HOME: begin
                if (tick) begin
                    if (pos_q > HOME_S) begin
                        pos_nxt = home_dn;
                        dir_nxt = 1'b0;
                    end else if (pos_q < -HOME_S) begin
                        pos_nxt = home_up;
                        dir_nxt = 1'b1;
                    end else begin
                        pos_nxt = ZERO;
                    end
                    if (pos_nxt == ZERO) begin
                        center_nxt = 1'b1;
                        dir_nxt    = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_q   <= (pwm_cnt < pos_mag(pos_q));
        end
    end

    always_comb begin
        bus.busy   = (state != IDLE);
        bus.pos    = pos_q;
        bus.dir    = dir_q;
        bus.center = center_q;
        bus.pwm    = pwm_q;
    end

endmodule

// File: tb/tb_rock_motion_gen.sv
// Directed bench for rock_motion_gen: per-tick expectations are queued by the
// stimulus and popped by a monitor after each motion tick.
module tb_rock_motion_gen;
    import rock_pkg::*;

    localparam int TD = 150;
    localparam int HS = 2;

    typedef struct {
        int pos;
        bit dir;
        bit busy;
        bit center;
    } exp_t;

    logic clk;
    logic reset;

    rock_motion_gen_if bus ();

    rock_motion_gen #(
        .TICK_DIV (TD),
        .HOME_STEP(HS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_cnt;
    bit   center_due = 1'b0;
    bit   center_exp = 1'b0;

    // Posedges since reset release; motion ticks land on multiples of TD.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_tick(input int p, input bit d, input bit b, input bit c);
        exp_t e;
        e.pos    = p;
        e.dir    = d;
        e.busy   = b;
        e.center = c;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int limit;
        int n;
        limit = (exp_q.size() + 2) * TD;
        n     = 0;
        while ((exp_q.size() != 0 || center_due) && n < limit) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0 || center_due) begin
            check("drain timeout", exp_q.size() + int'(center_due), 0);
            exp_q.delete();
            center_due = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " pos"},    int'(bus.pos),    0);
        check({tag, " dir"},    int'(bus.dir),    1);
        check({tag, " pwm"},    int'(bus.pwm),    0);
        check({tag, " center"}, int'(bus.center), 0);
        check({tag, " busy"},   int'(bus.busy),   0);
    endtask

    task automatic pwm_count(input string name, input int req);
        int hi;
        hi = 0;
        for (int i = 0; i < 128; i++) begin
            @(posedge clk);
            #2;
            hi += int'(bus.pwm);
        end
        check(name, hi, req);
    endtask

    // Monitor: after every tick edge, compare pos/dir/busy; one clk later, center.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && edge_cnt > 0 && (edge_cnt % TD) == 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick pos",  int'(bus.pos),  e.pos);
                check("tick dir",  int'(bus.dir),  int'(e.dir));
                check("tick busy", int'(bus.busy), int'(e.busy));
                center_exp = e.center;
                center_due = 1'b1;
            end else if (center_due) begin
                center_due = 1'b0;
                check("center", int'(bus.center), int'(center_exp));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        bus.A     = 3'd0;
        bus.F     = 3'd0;
        bus.error = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset("power-on reset");

        // Small swing (amp 16, step 3); A raised mid-swing takes effect only at the crossing.
        bus.A = 3'd1;
        bus.F = 3'd3;
        reset = 1'b1;
        expect_tick(3, 1, 1, 0);
        expect_tick(6, 1, 1, 0);
        expect_tick(9, 1, 1, 0);
        drain();
        bus.A = 3'd4;
        expect_tick(12, 1, 1, 0);
        expect_tick(15, 1, 1, 0);
        expect_tick(16, 0, 1, 0);
        for (int p = 13; p >= 1; p -= 3) expect_tick(p, 0, 1, 0);
        expect_tick(-2, 0, 1, 1);
        for (int k = 1; k <= 20; k++) expect_tick(-2 - 3 * k, 0, 1, 0);
        expect_tick(-64, 1, 1, 0);
        for (int k = 1; k <= 42; k++) expect_tick(-64 + 3 * k, 1, 1, k == 22);
        expect_tick(64, 0, 1, 0);
        drain();
        pwm_count("pwm high clks at pos=+64", 64);

        // F dropped to 0: next crossing sends the cradle home, then IDLE.
        bus.F = 3'd0;
        for (int k = 1; k <= 22; k++) expect_tick(64 - 3 * k, 0, 1, k == 22);
        expect_tick(0, 1, 0, 1);
        expect_tick(0, 1, 0, 0);
        expect_tick(0, 1, 0, 0);
        drain();
        pwm_count("pwm high clks at pos=0", 0);

        // Fault at +60: 30 homing ticks, held in IDLE while error stays high.
        bus.F = 3'd6;
        for (int k = 1; k <= 10; k++) expect_tick(6 * k, 1, 1, 0);
        drain();
        bus.error = 1'b1;
        for (int k = 1; k <= 30; k++) expect_tick(60 - 2 * k, k == 30, k != 30, k == 30);
        expect_tick(0, 1, 0, 0);
        expect_tick(0, 1, 0, 0);
        drain();
        bus.error = 1'b0;
        for (int k = 1; k <= 10; k++) expect_tick(6 * k, 1, 1, 0);
        expect_tick(64, 0, 1, 0);
        for (int k = 1; k <= 19; k++) expect_tick(64 - 6 * k, 0, 1, k == 11);
        drain();

        // Reset at pos=-50 clears everything at once; motion resumes TD clks after release.
        reset = 1'b0;
        #1;
        check_reset("reset mid-swing");
        bus.A = 3'd7;
        bus.F = 3'd7;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        for (int k = 1; k <= 15; k++) expect_tick(7 * k, 1, 1, 0);
        expect_tick(112, 0, 1, 0);
        expect_tick(105, 0, 1, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rock_motion_gen.md
# rock_motion_gen

Downstream stage of `FPGAControler`. Converts the 3-bit amplitude code `A`, the 3-bit frequency code `F` and `error` into a bounded triangular cradle position, a direction bit and a motor PWM. Setting changes are applied only at the centre crossing, so the cradle never jerks. On `error` the cradle is homed to centre and held there.

## Interface
- `TICK_DIV`, 1000: clk cycles per motion tick (≥2).
- `HOME_STEP`, 2: position step per tick while homing (1..7).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `A`  in  3  amplitude code from `FPGAControler`; 0 = stop.
- `F`  in  3  frequency code from `FPGAControler`; 0 = stop.
- `error`  in  1  controller fault; forces homing.
- `pos`  out  8  signed cradle position, range −112..+112.
- `dir`  out  1  1 = moving toward positive, 0 = negative.
- `pwm`  out  1  motor drive, duty proportional to |pos|.
- `center`  out  1  one-clk pulse when `pos` crosses or lands on 0.
- `busy`  out  1  high in RUN or HOME.

## Operation
- States:
  - IDLE: `pos`=0, `dir`=1.
  - RUN: triangle motion.
  - HOME: return to 0.
- Latched values:
  - `amp_l` = {A,4'b0} (7-bit unsigned, max 112).
  - `step_l` = F (3-bit).
- All motion happens only on `tick`. `tick` is high for one clk when the divider count equals TICK_DIV−1; the divider wraps to 0 on that cycle.
- IDLE: on tick with A≠0, F≠0 and `error`=0:
  - latch A/F, `pos` ← +F, state ← RUN.
  - Otherwise stay in IDLE.
- RUN, `dir`=1: next = pos+step_l. If next ≥ amp_l then `pos` ← amp_l and `dir` ← 0; else `pos` ← next.
- RUN, `dir`=0: symmetric. If next ≤ −amp_l then `pos` ← −amp_l and `dir` ← 1.
- Crossing: old pos>0 and new pos≤0, or old pos<0 and new pos≥0.
  - `center` pulses in the clk after the tick.
  - A and F are re-sampled on that same tick and take effect from the next tick.
  - If the sampled A=0 or F=0, state ← HOME.
- `error`=1 in RUN (checked on every clk, not only on tick): state ← HOME immediately. `pos` is held until the next tick.
- HOME: each tick `pos` moves toward 0 by HOME_STEP, clamped at 0.
  - `dir` reflects the direction of travel.
  - Reaching 0 pulses `center` and goes to IDLE with `dir`=1.
- `error` high in IDLE blocks the start. Start is allowed on the first tick after `error` falls.
- Arithmetic: evaluate in 9-bit signed, then clamp. Max |pos+step| = 119, which fits in 8-bit signed.
- PWM:
  - 7-bit free-running `pwm_cnt`, incrementing every clk and wrapping 127→0.
  - `pwm` = (`pwm_cnt` < |pos|), registered.
  - `pos`=0 gives constant 0. Duty = |pos|/128.

## Timing
- Reset values, all asynchronous: `pos`=0, `dir`=1, `pwm`=0, `center`=0, `busy`=0, state=IDLE, divider=0, `pwm_cnt`=0, `amp_l`=0, `step_l`=0.
- `pos`, `dir`, `busy` update on the clk edge at which `tick` is high.
- `center` lags that edge by one clk.
- `pwm` lags `pos` by one clk.
- First tick after reset release occurs TICK_DIV clks later.
- Full swing period in RUN: ≈ 4·amp/F ticks.
- Reset asserted mid-swing: outputs clear immediately. No homing ramp.
- `error` and a crossing on the same tick: `error` wins, state ← HOME.
- A/F changes between crossings are ignored.

## Structure
- Package `rock_pkg`:
  - state enum {IDLE, RUN, HOME}
  - AMP_SHIFT=4
  - POS_W=8
  - PWM_W=7
- Sub-module `rock_tick`: parameterised TICK_DIV divider with async active-low reset, one-clk `tick` output.
- FSM, position arithmetic and PWM stay in the top module.

## Test plan
- Reset, then hold A=7, F=7, TICK_DIV=4 → after 1 tick `pos`=7; `pos` ramps 14…105, then 112 with `dir`=0; next tick 105.
- A=1, F=3 in RUN; change A to 4 mid-swing → amplitude stays 16 until the `center` pulse, then peaks at 64.
- Set F=0 during RUN → HOME after the next crossing; `pos` reaches 0, IDLE, `busy`=0, one extra `center` pulse.
- Raise `error` at `pos`=+60 with HOME_STEP=2 → 30 ticks to 0; `busy` falls; stays IDLE while `error`=1; restarts on the first tick after `error` falls.
- Hold `pos`=+64 (A=4, F=0 forced) → `pwm` high exactly 64 of 128 clks; `pos`=0 → `pwm` constantly 0.
- Assert `reset` mid-swing at `pos`=−50 → all outputs at reset values immediately; first motion tick TICK_DIV clks after release.
